// File: rtl/mining_controller.sv
// Mining sequencer: loads a block header into BRAM, then sweeps a nonce range through an external hash core.
// Latency: header writes land one cycle after acceptance; 3 cycles per nonce plus hash-core latency.
// Backpressure: hdr_ready is high only while loading; each hash is waited on for at most TIMEOUT cycles.
module mining_controller #(
    parameter int HASH_W     = 256,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int HDR_WORDS  = 20,
    parameter int NONCE_ADDR = 19,
    parameter int DIFF_W     = 9,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DIFF_W-1:0] difficulty,
    input  logic [31:0]       nonce_start,
    input  logic [31:0]       nonce_end,
    input  logic              hdr_valid,
    input  logic [DATA_W-1:0] hdr_data,
    output logic              hdr_ready,
    output logic              bram_cs_n,
    output logic              bram_wr_n,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              hash_start,
    input  logic              hash_done,
    input  logic [HASH_W-1:0] hash_in,
    output logic              busy,
    output logic              found,
    output logic              exhausted,
    output logic              error,
    output logic [31:0]       nonce_out,
    output logic [31:0]       attempts,
    output logic [2:0]        state
);
    localparam int LZ_W   = $clog2(HASH_W + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    // ERROR shares code 7 with EXHAUST; the error flag tells them apart.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WR_NONCE  = 3'd2,
        ST_HASH_GO   = 3'd3,
        ST_HASH_WAIT = 3'd4,
        ST_CHECK     = 3'd5,
        ST_FOUND     = 3'd6,
        ST_EXHAUST   = 3'd7
    } state_t;

    typedef struct packed {
        logic              cs_n;
        logic              wr_n;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } bram_t;

    state_t              state_q, state_d;
    bram_t               bram_q, bram_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DIFF_W-1:0]   diff_q, diff_d;
    logic [31:0]         end_q, end_d;
    logic [31:0]         nonce_q, nonce_d;
    logic [31:0]         att_q, att_d;
    logic [HASH_W-1:0]   hash_q, hash_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                hash_start_q, hash_start_d;
    logic                hdr_ready_q, hdr_ready_d;
    logic                busy_q, busy_d;
    logic                found_q, found_d;
    logic                exh_q, exh_d;
    logic                err_q, err_d;

    logic [LZ_W-1:0]     lz;
    logic [31:0]         diff_eff;
    logic                hit;

    // Highest set bit wins, so lz ends up as the leading-zero count.
    always_comb begin
        lz = LZ_W'(HASH_W);
        for (int i = 0; i < HASH_W; i++) begin
            if (hash_q[i]) begin
                lz = LZ_W'(HASH_W - 1 - i);
            end
        end
    end

    assign diff_eff = (32'(diff_q) > 32'(HASH_W)) ? 32'(HASH_W) : 32'(diff_q);
    assign hit      = (32'(lz) >= diff_eff);

    always_comb begin
        state_d      = state_q;
        bram_d       = bram_q;
        bram_d.wr_n  = 1'b1;
        idx_d        = idx_q;
        diff_d       = diff_q;
        end_d        = end_q;
        nonce_d      = nonce_q;
        att_d        = att_q;
        hash_d       = hash_q;
        wait_d       = wait_q;
        hash_start_d = 1'b0;
        hdr_ready_d  = hdr_ready_q;
        found_d      = found_q;
        exh_d        = exh_q;
        err_d        = err_q;

        if (abort) begin
            state_d     = ST_IDLE;
            bram_d.cs_n = 1'b1;
            hdr_ready_d = 1'b0;
            found_d     = 1'b0;
            exh_d       = 1'b0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    bram_d.cs_n = 1'b1;
                    if (hdr_valid && hdr_ready_q) begin
                        bram_d.cs_n = 1'b0;
                        bram_d.wr_n = 1'b0;
                        bram_d.addr = idx_q;
                        bram_d.din  = hdr_data;
                        idx_d       = idx_q + 1'b1;
                        if (idx_q == ADDR_W'(HDR_WORDS - 1)) begin
                            state_d     = ST_WR_NONCE;
                            hdr_ready_d = 1'b0;
                        end
                    end
                end
                ST_WR_NONCE: begin
                    bram_d.cs_n = 1'b0;
                    bram_d.wr_n = 1'b0;
                    bram_d.addr = ADDR_W'(NONCE_ADDR);
                    bram_d.din  = DATA_W'(nonce_q);
                    state_d     = ST_HASH_GO;
                end
                ST_HASH_GO: begin
                    bram_d.cs_n  = 1'b0;
                    hash_start_d = 1'b1;
                    wait_d       = '0;
                    state_d      = ST_HASH_WAIT;
                end
                ST_HASH_WAIT: begin
                    bram_d.cs_n = 1'b0;
                    if (hash_done) begin
                        hash_d  = hash_in;
                        att_d   = (att_q == 32'hFFFF_FFFF) ? att_q : att_q + 32'd1;
                        state_d = ST_CHECK;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        err_d       = 1'b1;
                        bram_d.cs_n = 1'b1;
                        state_d     = ST_EXHAUST;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        found_d     = 1'b1;
                        bram_d.cs_n = 1'b1;
                        state_d     = ST_FOUND;
                    end else if (nonce_q == end_q) begin
                        exh_d       = 1'b1;
                        bram_d.cs_n = 1'b1;
                        state_d     = ST_EXHAUST;
                    end else begin
                        nonce_d = nonce_q + 32'd1;
                        state_d = ST_WR_NONCE;
                    end
                end
                default: begin
                    // IDLE and the terminal states: wait for a new job.
                    bram_d.cs_n = 1'b1;
                    hdr_ready_d = 1'b0;
                    if (start) begin
                        diff_d      = difficulty;
                        nonce_d     = nonce_start;
                        end_d       = nonce_end;
                        idx_d       = '0;
                        att_d       = '0;
                        found_d     = 1'b0;
                        exh_d       = 1'b0;
                        err_d       = 1'b0;
                        hdr_ready_d = 1'b1;
                        state_d     = ST_LOAD;
                    end
                end
            endcase
        end

        busy_d = (state_d == ST_LOAD)      || (state_d == ST_WR_NONCE) ||
                 (state_d == ST_HASH_GO)   || (state_d == ST_HASH_WAIT) ||
                 (state_d == ST_CHECK);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bram_q.cs_n  <= 1'b1;
            bram_q.wr_n  <= 1'b1;
            bram_q.addr  <= '0;
            bram_q.din   <= '0;
            idx_q        <= '0;
            diff_q       <= '0;
            end_q        <= '0;
            nonce_q      <= '0;
            att_q        <= '0;
            hash_q       <= '0;
            wait_q       <= '0;
            hash_start_q <= 1'b0;
            hdr_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exh_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bram_q       <= bram_d;
            idx_q        <= idx_d;
            diff_q       <= diff_d;
            end_q        <= end_d;
            nonce_q      <= nonce_d;
            att_q        <= att_d;
            hash_q       <= hash_d;
            wait_q       <= wait_d;
            hash_start_q <= hash_start_d;
            hdr_ready_q  <= hdr_ready_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            exh_q        <= exh_d;
            err_q        <= err_d;
        end
    end

    assign hdr_ready  = hdr_ready_q;
    assign bram_cs_n  = bram_q.cs_n;
    assign bram_wr_n  = bram_q.wr_n;
    assign bram_addr  = bram_q.addr;
    assign bram_din   = bram_q.din;
    assign hash_start = hash_start_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign exhausted  = exh_q;
    assign error      = err_q;
    assign nonce_out  = nonce_q;
    assign attempts   = att_q;
    assign state      = state_q;

endmodule

// File: doc/mining_controller.md
Name: mining_controller

Overview:
- Parametrised next-generation mining sequencer for the hashing datapath.
- Streams a block header into header BRAM, then iterates a 32-bit nonce over a programmable range.
- Per nonce: writes the nonce into BRAM, launches the hash core, waits for completion, and compares the leading-zero count against a runtime difficulty.
- Reports found / exhausted / timeout status, plus the winning nonce and the attempt count.

Parameters:
- HASH_W, 256: hash width in bits.
- DATA_W, 32: BRAM and header word width.
- ADDR_W, 16: BRAM address width.
- HDR_WORDS, 20: header words loaded per job (1..2^ADDR_W).
- NONCE_ADDR, 19: BRAM word address overwritten with the nonce.
- DIFF_W, 9: difficulty field width; values above HASH_W are clamped to HASH_W.
- TIMEOUT, 1024: maximum HASH_WAIT cycles before the error state (≥1).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- start  in  1  begin job (sampled in IDLE/FOUND/EXHAUST/ERROR)
- abort  in  1  cancel job, return to IDLE
- difficulty  in  DIFF_W  required leading zero bits, latched on start
- nonce_start  in  32  first nonce, latched on start
- nonce_end  in  32  last nonce (inclusive), latched on start
- hdr_valid  in  1  header word valid
- hdr_data  in  DATA_W  header word
- hdr_ready  out  1  header word accepted when valid&ready
- bram_cs_n  out  1  BRAM chip select, active-low
- bram_wr_n  out  1  BRAM write strobe, active-low
- bram_addr  out  ADDR_W  BRAM address
- bram_din  out  DATA_W  BRAM write data (nonce zero-extended or truncated to DATA_W)
- hash_start  out  1  one-cycle pulse launching the hash core
- hash_done  in  1  hash core result valid
- hash_in  in  HASH_W  hash result, MSB first
- busy  out  1  high in LOAD..CHECK
- found  out  1  sticky success
- exhausted  out  1  sticky: range searched, no hit
- error  out  1  sticky: hash core timeout
- nonce_out  out  32  current / winning nonce
- attempts  out  32  hashes evaluated this job, saturating at 0xFFFFFFFF
- state  out  3  current state code

Behaviour:
- Reset:
  - reset==0 at a clock edge forces state=IDLE(0) and returns all outputs to reset values.
  - Reset values: cs_n=1, wr_n=1, addr=0, din=0, hash_start=0, hdr_ready=0, busy=0, found=0, exhausted=0, error=0, nonce_out=0, attempts=0.
  - Reset has priority over abort, which has priority over start.
- All outputs are registered.
- State codes: IDLE=0, LOAD=1, WR_NONCE=2, HASH_GO=3, HASH_WAIT=4, CHECK=5, FOUND=6, EXHAUST=7. ERROR reuses code 7, distinguished by error=1.
- IDLE / FOUND / EXHAUST / ERROR:
  - start=1 latches difficulty, nonce_start and nonce_end; sets nonce_out=nonce_start, word index=0, clears attempts/found/exhausted/error.
  - Next state is LOAD.
- LOAD:
  - hdr_ready=1.
  - Each accepted word is written to BRAM in the following cycle: addr=index, din=hdr_data, cs_n=0, wr_n=0 for exactly one cycle; index increments.
  - Gaps in hdr_valid insert idle cycles with wr_n=1.
  - On acceptance of word HDR_WORDS-1, hdr_ready drops to 0 in the next cycle and the state moves to WR_NONCE.
- WR_NONCE: one-cycle write, addr=NONCE_ADDR, din=nonce_out, wr_n=0; then HASH_GO. The nonce overrides any header word at that address.
- HASH_GO: hash_start=1 for exactly one cycle; cs_n=0, wr_n=1 (read mode for the hash core); then HASH_WAIT.
- HASH_WAIT:
  - On hash_done=1: capture hash_in, attempts+=1 (saturating), go to CHECK.
  - After TIMEOUT cycles without hash_done: error=1, cs_n=1, go to ERROR.
- CHECK: lz = number of leading zero bits of the captured hash (0..HASH_W).
  - lz ≥ min(difficulty, HASH_W): FOUND; found=1, nonce_out holds the winning nonce.
  - Else nonce_out==nonce_end: EXHAUST; exhausted=1.
  - Else nonce_out+1 (mod 2^32), then WR_NONCE.
- difficulty=0 always hits on the first nonce.
- Range wraps: nonce_end < nonce_start sweeps through 0xFFFFFFFF→0. nonce_start==nonce_end gives exactly one attempt.
- Terminal states hold cs_n=1, wr_n=1, busy=0.
- abort=1 in any state: next cycle IDLE with cs_n=1, wr_n=1, hash_start=0, hdr_ready=0; a pending BRAM write is dropped. Status flags are cleared; attempts and nonce_out are held.
- hash_done outside HASH_WAIT is ignored.
- Throughput per nonce: 3 cycles plus hash-core latency.

Test Plan:
- Load 20 words (0x1000+i, no gaps); hash model returns 12 leading zeros only at nonce 5; difficulty=10, range 0..100 → 20 writes to addr 0..19, nonce writes 0..5 at addr 19, found=1, nonce_out=5, attempts=6.
- difficulty=0, nonce_start=0xABCD → found after first hash, attempts=1, nonce_out=0xABCD.
- Range 0xFFFFFFFE..0x00000001, hash never meets difficulty=20 → nonce writes FFFFFFFE, FFFFFFFF, 0, 1; exhausted=1; attempts=4.
- hash_done never asserted, TIMEOUT=16 → error=1 exactly 16 cycles after hash_start, state=7, busy=0.
- hdr_valid toggling 1/0 → one write per accepted word, no duplicate or skipped addresses. Also: abort during LOAD word 7 → IDLE next cycle, no further writes.
- reset=0 during HASH_WAIT → all outputs at reset values next edge. Then start → fresh job from index 0 with attempts reset to 0.
